e_mdu: RTL
==========

Name: e_mdu

Overview:
Multiply/divide unit in the E stage of the five-stage pipeline. It consumes the mult/multu/div/divu/mthi/mtlo/mfhi/mflo decode carried forward from D, along with the forwarded rs/rt operand values. It models multi-cycle latency with a busy counter and owns the architectural HI/LO registers. Its START/BUSY outputs feed the stall logic that holds any HI/LO-touching instruction in D.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
MDUOP_E  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none)
RS_E  input  32  forwarded rs value; multiplicand/dividend/mthi/mtlo source
RT_E  input  32  forwarded rt value; multiplier/divisor
HLSEL_E  input  1  read select for MDOUT_E: 0 = LO (mflo), 1 = HI (mfhi)
START  output  1  combinational; high when MDUOP_E is mult/multu/div/divu, state is IDLE and reset is low
BUSY  output  1  registered; high while an operation is in flight
MD_STALL  output  1  START | BUSY; consumed by the D-stage hazard logic
HI  output  32  architectural HI register
LO  output  32  architectural LO register
MDOUT_E  output  32  HLSEL_E ? HI : LO, combinational from the registers

Behaviour:
- Reset (sync, active-high): HI=0, LO=0, BUSY=0, count=0, pending result regs=0, state=IDLE. Reset wins over every other event in the same cycle.
- States: IDLE, RUN. A 4-bit down-counter runs in RUN.
- IDLE + START at edge k:
  - Latch the pending result, computed from RS_E/RT_E in that cycle.
  - count <= MULT_CYCLES or DIV_CYCLES as applicable; go to RUN.
  - BUSY is high for cycles k+1 .. k+N.
- RUN, each edge: count decrements.
  - At the edge where count==1: HI/LO <= pending result, BUSY <= 0, state <= IDLE.
  - New values are visible in cycle k+N+1, the same cycle BUSY first reads low.
- Operand latching: operands are sampled only at the START edge. Later changes on RS_E/RT_E have no effect on the result.
- mult: signed 32x32 -> 64-bit product; HI = product[63:32], LO = product[31:0].
- multu: same as mult, unsigned.
- div: signed division; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu: unsigned division; LO = quotient, HI = remainder.
- Divide by zero (div or divu, RT_E==0):
  - BUSY timing is unchanged (N=DIV_CYCLES).
  - HI/LO keep their prior values at completion; no other side effect.
- mthi/mtlo in IDLE: HI (or LO) <= RS_E at the next edge; BUSY stays 0; single cycle. mfhi/mflo read MDOUT_E in the cycle after the write and see the new value.
- Any nonzero MDUOP_E while BUSY=1 is ignored. This includes mult/div, so START=0, and mthi/mtlo. The stall logic guarantees this never happens; the bench checks for it.
- Back-to-back operations:
  - A new mult/div may start in cycle k+N+1.
  - If that op is mthi/mtlo, it writes at the edge ending k+N+1, overwriting that half of the just-committed result.
- Reset mid-RUN: the pending result is discarded, HI/LO=0, BUSY=0 on the next cycle.
- MDOUT_E is never stalled internally. During BUSY it returns the old HI/LO; the stall logic keeps mfhi/mflo from reaching E during BUSY.

Test Plan:
- mult RS=0xFFFFFFFD (-3), RT=5 -> START=1 for 1 cycle, BUSY=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu RS=0xFFFFFFFF, RT=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE. RS/RT changed to 0 during BUSY -> result unaffected.
- Signed div:
  - div RS=0xFFFFFFF9 (-7), RT=2 -> BUSY for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - divu 7/2 -> LO=3, HI=1.
- Divide by zero: preload mthi 0x1234, mtlo 0x5678, then div RT=0 -> BUSY for 10 cycles, then HI=0x1234, LO=0x5678 unchanged.
- Ignored ops during BUSY: mtlo 0xAAAA issued while BUSY -> ignored. After completion, mtlo 0xAAAA -> next cycle HLSEL_E=0 gives MDOUT_E=0xAAAA. HLSEL_E=1 gives the current HI.
- Reset mid-RUN: reset asserted in BUSY cycle 3 of a mult -> next cycle BUSY=0, HI=LO=0. No late commit occurs in the following 10 cycles.

Source files
------------

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO and models multi-cycle latency
// with a busy down-counter feeding the D-stage stall logic.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDUOP_E,
  input  logic [31:0] RS_E,
  input  logic [31:0] RT_E,
  input  logic        HLSEL_E,
  output logic        START,
  output logic        BUSY,
  output logic        MD_STALL,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOUT_E
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic        pwr_q, pwr_d;

  logic        is_md;
  logic        is_mul;
  logic [63:0] rs_w, rt_w;
  logic [63:0] sprod, uprod;
  logic [31:0] dvs, sq, sr, uq, ur;
  logic        ovf;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  assign is_md  = (MDUOP_E == OP_MULT) || (MDUOP_E == OP_MULTU) ||
                  (MDUOP_E == OP_DIV)  || (MDUOP_E == OP_DIVU);
  assign is_mul = (MDUOP_E == OP_MULT) || (MDUOP_E == OP_MULTU);

  assign START    = is_md && (state_q == S_IDLE) && !reset;
  assign BUSY     = busy_q;
  assign MD_STALL = START | BUSY;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign MDOUT_E  = HLSEL_E ? hi_q : lo_q;

  // Divisor forced to 1 on /0 and on signed overflow so the
  // arithmetic stays defined; both cases are resolved below.
  always_comb begin
    rs_w  = {{32{RS_E[31]}}, RS_E};
    rt_w  = {{32{RT_E[31]}}, RT_E};
    sprod = rs_w * rt_w;
    uprod = {32'b0, RS_E} * {32'b0, RT_E};
    ovf   = (RS_E == 32'h8000_0000) && (RT_E == 32'hFFFF_FFFF);
    dvs   = ((RT_E == 32'b0) || ovf) ? 32'd1 : RT_E;
    sq    = $signed(RS_E) / $signed(dvs);
    sr    = $signed(RS_E) % $signed(dvs);
    uq    = RS_E / dvs;
    ur    = RS_E % dvs;
    res_hi = 32'b0;
    res_lo = 32'b0;
    res_wr = 1'b1;
    case (MDUOP_E)
      OP_MULT:  {res_hi, res_lo} = sprod;
      OP_MULTU: {res_hi, res_lo} = uprod;
      OP_DIV: begin
        res_wr = (RT_E != 32'b0);
        if (ovf) begin
          res_hi = 32'b0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      OP_DIVU: begin
        res_wr = (RT_E != 32'b0);
        res_hi = ur;
        res_lo = uq;
      end
      default: res_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          phi_d   = res_hi;
          plo_d   = res_lo;
          pwr_d   = res_wr;
          count_d = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else if (MDUOP_E == OP_MTHI) begin
          hi_d = RS_E;
        end else if (MDUOP_E == OP_MTLO) begin
          lo_d = RS_E;
        end
      end
      S_RUN: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'b0;
      lo_q    <= 32'b0;
      phi_q   <= 32'b0;
      plo_q   <= 32'b0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

endmodule
